// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction memory it feeds.
package instruction_loader_pkg;

    localparam int MEM_SIZE_DEF = 16000;
    localparam int ADDR_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_DATA,
        ST_CHECKSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the loader.
interface instruction_loader_if import instruction_loader_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_write_enable;
    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_write_data;
    logic              load_done;
    logic              load_error;
    logic              checksum_error;

    modport master (
        output rx_data, rx_valid,
        input  imem_write_enable, imem_address, imem_write_data,
        input  load_done, load_error, checksum_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output imem_write_enable, imem_address, imem_write_data,
        output load_done, load_error, checksum_error
    );
endinterface

// File: rtl/instruction_loader_byte_packer.sv
// 8->32 big-endian packer; word/word_valid present the completed word in the cycle of its 4th byte.
module instruction_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    // Only the three oldest bytes need storage; the fourth arrives live.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    assign word       = {shift_q, byte_data};
    assign word_valid = byte_valid && !clr && (cnt_q == 2'd3);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = word[23:0];
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed big-endian program image from a byte stream into instruction memory.
// Optional CHECKSUM_EN: a trailing sum word is verified against the mod-2^32 sum of the data words.
module instruction_loader import instruction_loader_pkg::*; #(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reload,
    instruction_loader_if.slave bus
);
    localparam logic [31:0] MAX_WORDS = 32'(MEM_SIZE);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d, addr_q, addr_d;
    logic [31:0]       n_q, n_d, data_q, data_d;
    logic              we_q, we_d, done_q, done_d, err_q, err_d;
    logic [31:0]       word;
    logic              word_valid, accept, last_word;
`ifdef CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
    logic              cks_err_q, cks_err_d;
`endif

    // Bytes arriving after the image is finished or rejected never reach the packer.
    assign accept    = bus.rx_valid && (state_q inside {ST_HEADER, ST_DATA, ST_CHECKSUM});
    assign last_word = (wcnt_q == ADDR_W'(n_q - 32'd1));

    instruction_loader_byte_packer u_byte_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (reload),
        .byte_valid(accept),
        .byte_data (bus.rx_data),
        .word      (word),
        .word_valid(word_valid)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        n_d     = n_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef CHECKSUM_EN
        sum_d     = sum_q;
        cks_err_d = cks_err_q;
`endif
        if (reload) begin
            state_d = ST_HEADER;
            wcnt_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef CHECKSUM_EN
            sum_d     = '0;
            cks_err_d = 1'b0;
`endif
        end else if (word_valid) begin
            case (state_q)
                ST_HEADER: begin
                    n_d    = word;
                    wcnt_d = '0;
`ifdef CHECKSUM_EN
                    sum_d  = '0;
`endif
                    if (word == 32'd0) begin
`ifdef CHECKSUM_EN
                        state_d = ST_CHECKSUM;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else if (word > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    we_d   = 1'b1;
                    addr_d = wcnt_q;
                    data_d = word;
                    wcnt_d = wcnt_q + ADDR_W'(1);
`ifdef CHECKSUM_EN
                    sum_d  = sum_q + word;
                    if (last_word) state_d = ST_CHECKSUM;
`else
                    if (last_word) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
`endif
                end
`ifdef CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (word == sum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_ERROR;
                        err_d     = 1'b1;
                        cks_err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HEADER;
            wcnt_q  <= '0;
            n_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q     <= '0;
            cks_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            n_q     <= n_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef CHECKSUM_EN
            sum_q     <= sum_d;
            cks_err_q <= cks_err_d;
`endif
        end
    end

    assign bus.imem_write_enable = we_q;
    assign bus.imem_address      = addr_q;
    assign bus.imem_write_data   = data_q;
    assign bus.load_done         = done_q;
    assign bus.load_error        = err_q;
`ifdef CHECKSUM_EN
    assign bus.checksum_error    = cks_err_q;
`else
    assign bus.checksum_error    = 1'b0;
`endif
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Upstream stage of the instruction memory. Receives a serial byte stream from the UART receiver and packs it into 32-bit instruction words.
- Writes each word into instruction memory through its write port (write enable, 16-bit word address, 32-bit data) and signals when the program image is complete.
- The CPU is held off fetching until load_done asserts.

Parameters:
- MEM_SIZE, 16000: instruction memory depth in words; larger word counts are rejected.
- ADDR_W, 16: word address width; matches the instruction memory address port.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- reload  in  1  synchronous pulse; aborts any load and restarts at header reception.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- imem_write_enable  out  1  one-cycle write strobe to instruction memory.
- imem_address  out  ADDR_W  word address of the write.
- imem_write_data  out  32  instruction word.
- load_done  out  1  program fully written; held until reload or reset.
- load_error  out  1  rejected image; sticky until reload or reset.
- checksum_error  out  1  checksum mismatch; only when CHECKSUM_EN is defined, otherwise tied 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=HEADER, byte counter=0, word counter=0, shift register=0.
  - All outputs 0.
- Stream format, all fields big-endian (first byte = bits 31:24):
  - A 4-byte word count N.
  - Then N 4-byte instruction words.
- Byte assembly: on each rx_valid, shift = {shift[23:0], rx_data} and the byte counter increments mod 4. The 4th byte completes a word.
- States:
  - HEADER:
    - On word completion, latch N.
    - N=0 → DONE next cycle.
    - N>MEM_SIZE → ERROR.
    - Otherwise → DATA with word counter=0.
  - DATA:
    - On word completion, the next cycle drives imem_write_enable=1, imem_address=word counter, imem_write_data=assembled word (latency 1 cycle after the 4th rx_valid).
    - Word counter then increments.
    - After the write with word counter = N-1 → DONE (or → CHECKSUM when CHECKSUM_EN is defined).
  - DONE: load_done=1; rx_valid ignored; no writes.
  - ERROR: load_error=1; rx_valid ignored; no writes.
- imem_write_enable is high for exactly one cycle per word. imem_address and imem_write_data hold their last value otherwise.
- Back-to-back rx_valid on consecutive cycles is supported; the write-pulse pipeline never drops a byte.
- reload:
  - Synchronous. From any state → HEADER; clears counters, load_done, load_error and checksum_error.
  - reload and rx_valid in the same cycle: reload wins and the byte is discarded.
  - A pending write pulse from the previous cycle still completes.
- Word count is compared as a 32-bit unsigned value. The address counter never exceeds MEM_SIZE-1, so it never wraps.
- rst_n asserted mid-load: immediate abort. Memory contents already written are left untouched.

Optional Feature:
- CHECKSUM_EN
- Defined:
  - After N data words, one additional 4-byte word is received in state CHECKSUM.
  - It is compared to the running 32-bit sum (mod 2^32) of all N data words.
  - Match: → DONE.
  - Mismatch: checksum_error=1 and → ERROR (load_error=1).
  - The checksum word is never written to memory.
  - For N=0 the checksum word is still expected and must equal 0.
- Not defined: no CHECKSUM state, no accumulator, checksum_error constant 0, DATA → DONE directly.

Decomposition:
- Shared package holds:
  - The state encoding (HEADER, DATA, CHECKSUM, DONE, ERROR).
  - MEM_SIZE and ADDR_W defaults, shared with instruction memory.
- One natural sub-module, byte_packer: 8→32 big-endian shift register with 2-bit byte counter, a word_valid pulse output, and a synchronous clear.

Test Plan:
- Header 00 00 00 02, words DEADBEEF, 00000013 → writes (0,DEADBEEF), (1,00000013); each write one cycle after its 4th byte; load_done=1 after the second write.
- Header 00 00 00 00 → no writes; load_done=1 one cycle after the header completes.
- Header 00 00 3E 81 (16001) → load_error=1; following bytes produce no writes; reload then a valid 1-word image → load_done=1, load_error=0.
- reload asserted after 6 of 8 data bytes, same cycle as rx_valid → the byte is dropped; a fresh header 00000001 with word 12345678 → single write (0,12345678).
- rx_valid on every cycle for a 3-word image → three write pulses with no gaps or losses; addresses 0, 1, 2.
- CHECKSUM_EN: words 00000001, 00000002 with checksum 00000003 → load_done=1. Same words with checksum 00000004 → checksum_error=1, load_error=1, load_done=0.
